// File: rtl/regfile_write_arbiter.sv
// Write-port owner for the register file: round-robin arbitration between ALU (A)
// and load (B) writeback, with a registered write stage and a 1..N-1 clear sweep.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int START_PRIORITY = 0
) (
    input  logic                  clock,
    input  logic                  ctrl_reset_n,
    input  logic                  ctrl_clear,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [ADDR_WIDTH-1:0] a_reg,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [ADDR_WIDTH-1:0] b_reg,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  ctrl_writeEnable,
    output logic [ADDR_WIDTH-1:0] ctrl_writeReg,
    output logic [DATA_WIDTH-1:0] data_writeReg,
    output logic                  busy
);

    typedef enum logic {
        ARB,
        CLEAR
    } state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] count, count_next;
    logic                  last_grant, last_grant_next;   // 1 = B won the last transfer
    logic                  we_next;
    logic [ADDR_WIDTH-1:0] wreg_next;
    logic [DATA_WIDTH-1:0] wdata_next;
    logic                  grant_a, grant_b;

    assign grant_a = a_valid && (!b_valid || last_grant);
    assign grant_b = b_valid && (!a_valid || !last_grant);

    always_comb begin
        state_next      = state;
        count_next      = count;
        last_grant_next = last_grant;
        we_next         = 1'b0;
        wreg_next       = ctrl_writeReg;
        wdata_next      = data_writeReg;
        a_ready         = 1'b0;
        b_ready         = 1'b0;
        busy            = (state == CLEAR);

        case (state)
            ARB: begin
                if (ctrl_clear) begin
                    state_next = CLEAR;
                    count_next = ADDR_WIDTH'(1);
                end else begin
                    a_ready = ctrl_reset_n && grant_a;
                    b_ready = ctrl_reset_n && grant_b;
                    // Register 0 is hardwired zero: accept the write but suppress the enable.
                    if (grant_a) begin
                        we_next         = (a_reg != '0);
                        wreg_next       = a_reg;
                        wdata_next      = a_data;
                        last_grant_next = 1'b0;
                    end else if (grant_b) begin
                        we_next         = (b_reg != '0);
                        wreg_next       = b_reg;
                        wdata_next      = b_data;
                        last_grant_next = 1'b1;
                    end
                end
            end
            CLEAR: begin
                we_next    = 1'b1;
                wreg_next  = count;
                wdata_next = '0;
                count_next = count + ADDR_WIDTH'(1);
                if (count == '1) begin
                    state_next = ARB;
                end
            end
            default: begin
                state_next = ARB;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            state            <= ARB;
            count            <= '0;
            last_grant       <= (START_PRIORITY == 0);
            ctrl_writeEnable <= 1'b0;
            ctrl_writeReg    <= '0;
            data_writeReg    <= '0;
        end else begin
            state            <= state_next;
            count            <= count_next;
            last_grant       <= last_grant_next;
            ctrl_writeEnable <= we_next;
            ctrl_writeReg    <= wreg_next;
            data_writeReg    <= wdata_next;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios followed by
// randomised A/B traffic against a transaction-level reference model.
module tb_regfile_write_arbiter;

    logic        clock;
    logic        ctrl_reset_n;
    logic        ctrl_clear;
    logic        a_valid, a_ready;
    logic [4:0]  a_reg;
    logic [31:0] a_data;
    logic        b_valid, b_ready;
    logic [4:0]  b_reg;
    logic [31:0] b_data;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic        busy;

    int checks = 0;
    int errors = 0;

    regfile_write_arbiter #(
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (5),
        .START_PRIORITY(0)
    ) dut (
        .clock           (clock),
        .ctrl_reset_n    (ctrl_reset_n),
        .ctrl_clear      (ctrl_clear),
        .a_valid         (a_valid),
        .a_ready         (a_ready),
        .a_reg           (a_reg),
        .a_data          (a_data),
        .b_valid         (b_valid),
        .b_ready         (b_ready),
        .b_reg           (b_reg),
        .b_data          (b_data),
        .ctrl_writeEnable(ctrl_writeEnable),
        .ctrl_writeReg   (ctrl_writeReg),
        .data_writeReg   (data_writeReg),
        .busy            (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic half();
        @(negedge clock);
    endtask

    task automatic edge_();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        ctrl_reset_n = 1'b0;
        ctrl_clear   = 1'b0;
        a_valid      = 1'b0;
        b_valid      = 1'b0;
        edge_();
        edge_();
        ctrl_reset_n = 1'b1;
    endtask

    task automatic check_out(input string tag, input logic we, input logic [4:0] r, input logic [31:0] d);
        check({tag, ".we"},   64'(ctrl_writeEnable), 64'(we));
        check({tag, ".reg"},  64'(ctrl_writeReg),    64'(r));
        check({tag, ".data"}, 64'(data_writeReg),    64'(d));
    endtask

    // Reference model state for the randomised phase
    bit          pa, pb;
    logic [4:0]  ra, rb;
    logic [31:0] da, db;
    bit          tie_to_a;
    logic        m_we;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    logic        ea, eb;

    initial begin
        ctrl_reset_n = 1'b0;
        ctrl_clear   = 1'b0;
        a_valid = 1'b1; a_reg = 5'd3; a_data = 32'h3;
        b_valid = 1'b0; b_reg = '0;   b_data = '0;

        // Reset: readys forced low even with a request pending
        half();
        check("rst.a_ready", 64'(a_ready), 64'd0);
        edge_();
        check_out("rst", 1'b0, 5'd0, 32'd0);
        check("rst.busy", 64'(busy), 64'd0);
        a_valid = 1'b0;
        edge_();
        ctrl_reset_n = 1'b1;

        // Single A write, latency 1
        a_valid = 1'b1; a_reg = 5'd5; a_data = 32'hDEADBEEF;
        half();
        check("t1.a_ready", 64'(a_ready), 64'd1);
        check("t1.b_ready", 64'(b_ready), 64'd0);
        edge_();
        check_out("t1.w", 1'b1, 5'd5, 32'hDEADBEEF);
        a_valid = 1'b0;
        half();
        check("t1.idle_ready", 64'(a_ready), 64'd0);
        edge_();
        check_out("t1.idle", 1'b0, 5'd5, 32'hDEADBEEF);

        // Round-robin on a sustained tie
        do_reset();
        a_valid = 1'b1; a_reg = 5'd1; a_data = 32'h11;
        b_valid = 1'b1; b_reg = 5'd2; b_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            half();
            check("t2.a_ready", 64'(a_ready), 64'(i % 2 == 0));
            check("t2.b_ready", 64'(b_ready), 64'(i % 2 == 1));
            edge_();
            if (i % 2 == 0) check_out("t2.wA", 1'b1, 5'd1, 32'h11);
            else            check_out("t2.wB", 1'b1, 5'd2, 32'h22);
        end
        a_valid = 1'b0; b_valid = 1'b0;

        // Write to reg 0 is accepted without enable and still moves priority
        b_valid = 1'b1; b_reg = 5'd0; b_data = 32'hFFFFFFFF;
        half();
        check("t3.b_ready", 64'(b_ready), 64'd1);
        edge_();
        check_out("t3.r0", 1'b0, 5'd0, 32'hFFFFFFFF);
        a_valid = 1'b1; a_reg = 5'd7; a_data = 32'h77;
        b_reg = 5'd8; b_data = 32'h88;
        half();
        check("t3.tie_a", 64'(a_ready), 64'd1);
        check("t3.tie_b", 64'(b_ready), 64'd0);
        edge_();
        check_out("t3.w", 1'b1, 5'd7, 32'h77);
        a_valid = 1'b0; b_valid = 1'b0;
        edge_();

        // Clear sweep with A pending; a second clear mid-sweep is ignored
        a_valid = 1'b1; a_reg = 5'd9; a_data = 32'h99;
        ctrl_clear = 1'b1;
        half();
        check("t4.clr_ready", 64'(a_ready), 64'd0);
        edge_();
        ctrl_clear = 1'b0;
        check("t4.busy0", 64'(busy), 64'd1);
        check("t4.we0", 64'(ctrl_writeEnable), 64'd0);
        for (int r = 1; r <= 31; r++) begin
            ctrl_clear = (r == 5);
            half();
            check("t4.ready_in_clear", 64'(a_ready), 64'd0);
            edge_();
            check_out("t4.clr", 1'b1, 5'(r), 32'd0);
            check("t4.busy", 64'(busy), 64'(r < 31));
        end
        ctrl_clear = 1'b0;
        half();
        check("t4.ready_after", 64'(a_ready), 64'd1);
        edge_();
        check_out("t4.wA", 1'b1, 5'd9, 32'h99);
        a_valid = 1'b0;
        edge_();

        // Reset in the middle of a sweep aborts it
        ctrl_clear = 1'b1;
        edge_();
        ctrl_clear = 1'b0;
        for (int r = 1; r <= 10; r++) begin
            edge_();
            check_out("t5.clr", 1'b1, 5'(r), 32'd0);
        end
        ctrl_reset_n = 1'b0;
        edge_();
        check_out("t5.rst", 1'b0, 5'd0, 32'd0);
        check("t5.busy", 64'(busy), 64'd0);
        ctrl_reset_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            edge_();
            check("t5.no_we", 64'(ctrl_writeEnable), 64'd0);
            check("t5.no_busy", 64'(busy), 64'd0);
        end

        // Randomised traffic against the reference model
        do_reset();
        pa = 0; pb = 0;
        tie_to_a = 1;
        m_we = 1'b0; m_reg = '0; m_data = '0;
        check_out("rnd.init", m_we, m_reg, m_data);
        for (int c = 0; c < 1000; c++) begin
            if (!pa && $urandom_range(0, 2) != 0) begin
                pa = 1; ra = 5'($urandom_range(0, 31)); da = $urandom;
            end
            if (!pb && $urandom_range(0, 2) != 0) begin
                pb = 1; rb = 5'($urandom_range(0, 31)); db = $urandom;
            end
            a_valid = pa; a_reg = pa ? ra : 5'($urandom); a_data = pa ? da : $urandom;
            b_valid = pb; b_reg = pb ? rb : 5'($urandom); b_data = pb ? db : $urandom;

            if (pa && pb) begin
                ea = tie_to_a; eb = !tie_to_a;
            end else begin
                ea = pa; eb = pb;
            end
            half();
            check("rnd.a_ready", 64'(a_ready), 64'(ea));
            check("rnd.b_ready", 64'(b_ready), 64'(eb));
            check("rnd.one_hot", 64'(a_ready && b_ready), 64'd0);

            m_we = 1'b0;
            if (ea) begin
                m_we = (ra != 0); m_reg = ra; m_data = da; pa = 0; tie_to_a = 0;
            end else if (eb) begin
                m_we = (rb != 0); m_reg = rb; m_data = db; pb = 0; tie_to_a = 1;
            end
            edge_();
            check_out("rnd.w", m_we, m_reg, m_data);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port of the 32x32 register file and shares it between two writeback requesters: port A (ALU writeback) and port B (load writeback).
- Arbitrates round-robin with a valid/ready handshake and registers the winning write onto the regfile write-port signals.
- Provides a clear sequencer that zeroes registers 1..31 on command.
- Sits between the execute/memory stages and the register file.

Parameters:
- DATA_WIDTH, 32, width of write data.
- ADDR_WIDTH, 5, width of register index; register count is 2**ADDR_WIDTH.
- START_PRIORITY, 0, port favoured on the first tie after reset (0 = A, 1 = B).

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- ctrl_reset_n  in  1  synchronous, active-low reset.
- ctrl_clear  in  1  single-cycle request to zero registers 1..31.
- a_valid  in  1  port A write request.
- a_ready  out  1  port A request accepted this cycle.
- a_reg  in  ADDR_WIDTH  port A destination register.
- a_data  in  DATA_WIDTH  port A write data.
- b_valid  in  1  port B write request.
- b_ready  out  1  port B request accepted this cycle.
- b_reg  in  ADDR_WIDTH  port B destination register.
- b_data  in  DATA_WIDTH  port B write data.
- ctrl_writeEnable  out  1  regfile write enable, registered.
- ctrl_writeReg  out  ADDR_WIDTH  regfile write index, registered.
- data_writeReg  out  DATA_WIDTH  regfile write data, registered.
- busy  out  1  high while the clear sequence runs.

Behaviour:
- Clock and reset: one clock. ctrl_reset_n is synchronous and active-low.
- Reset (ctrl_reset_n=0 at an edge):
  - ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, busy=0.
  - State=ARB; clear counter=0; last_grant set so the START_PRIORITY port wins the first tie.
  - a_ready and b_ready are forced to 0 while ctrl_reset_n=0.
  - Reset mid-clear aborts the sweep; no further clear writes are issued.
- States: ARB and CLEAR.
- ARB, grant selection (combinational):
  - ctrl_clear=1: no grant; a_ready=b_ready=0; next state CLEAR, counter=1. Clear beats pending requests in the same cycle.
  - Only one valid: that port is granted.
  - Both valid: the port other than last_grant is granted.
  - ready is asserted only on the granted port. a_ready and b_ready are never both 1, and ready is never 1 without the matching valid.
- Handshake rules:
  - Transfer occurs when valid and ready are both 1 at an edge.
  - A requester holds valid, reg and data stable until accepted; valid does not drop before acceptance.
  - One transfer per cycle maximum; back-to-back transfers run at full throughput.
- Write output (latency 1):
  - At the edge of an accepted transfer, the output registers load the winner's reg and data.
  - ctrl_writeEnable loads 1, except when reg==0: the transfer is still accepted but ctrl_writeEnable=0, since register 0 is hardwired zero.
  - With no transfer, ctrl_writeEnable loads 0; ctrl_writeReg and data_writeReg hold their values.
  - last_grant updates only on a transfer, including one to reg 0.
- CLEAR:
  - busy=1 for every cycle in CLEAR; both readys are 0.
  - At each edge: ctrl_writeEnable=1, ctrl_writeReg=counter, data_writeReg=0, then counter increments.
  - The edge that loads index 2**ADDR_WIDTH-1 returns the state to ARB.
  - Timing with ctrl_clear seen at edge k:
    - Writes to registers 1..31 appear after edges k+1 .. k+31.
    - busy is high after edges k .. k+30.
    - Requests can be accepted in the cycle after edge k+31; the first such write appears after edge k+32.
  - ctrl_clear is ignored while in CLEAR. Requests pending during CLEAR stay pending and are arbitrated normally afterwards.
  - last_grant is unchanged by CLEAR.

Test Plan:
- Reset, then a_valid=1, a_reg=5, a_data=0xDEADBEEF: a_ready=1 the same cycle; next cycle ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0xDEADBEEF; the cycle after, ctrl_writeEnable=0.
- Both ports valid and held for 4 cycles (A: reg 1, data 0x11; B: reg 2, data 0x22), START_PRIORITY=0: grants go A, B, A, B; output writes alternate reg 1/2 with data 0x11/0x22 on consecutive cycles.
- b_valid=1, b_reg=0, b_data=0xFFFFFFFF: b_ready=1; next cycle ctrl_writeEnable=0. A following tie between A and B is granted to A.
- ctrl_clear pulsed while a_valid=1: a_ready=0; busy high for 31 cycles; writes of 0 to regs 1..31, one per cycle, with no gaps; a_ready rises in the cycle after the reg-31 write edge; A's write appears on the next cycle.
- Assert ctrl_reset_n=0 after the reg-10 clear write: next cycle busy=0 and all outputs 0; no writes to regs 11..31 follow.
- Randomised A/B traffic for 1000 cycles, checked against a reference model: every accepted request appears exactly once, in grant order, with latency 1; the two readys are never simultaneously 1.
